led_dim_ctrl: RTL and testbench
===============================

# led_dim_ctrl

- Single-button LED dimmer controller, driven by one-cycle `rise`/`fall` pulses from the upstream edge detector.
- Short press toggles the lamp on/off; long hold ramps brightness, alternating direction on each successive hold.
- Owns the brightness register and drives the LED pin through a PWM generator.
- Sits between the button edge detector and the board LED output.

## Interface

Parameters:
- `DUTY_W`, 8: brightness width; PWM period = 2^DUTY_W clocks.
- `HOLD_CYC`, 25_000_000: press length in cycles that qualifies as a long press.
- `STEP_CYC`, 390_625: cycles per brightness step while ramping.

Ports:
- `clk`  in  1  system clock, posedge active.
- `rst`  in  1  reset, synchronous, active-high.
- `rise`  in  1  one-cycle pulse, button pressed.
- `fall`  in  1  one-cycle pulse, button released.
- `level`  out  DUTY_W  current brightness.
- `led_on`  out  1  lamp enabled.
- `pwm_out`  out  1  LED drive.

## Operation

- Reset values (asserted at the next posedge with `rst`=1):
  - state OFF, `led_on`=0, `pwm_out`=0, `level`=2^DUTY_W-1.
  - ramp direction = DOWN; hold, step and PWM counters = 0.
- States: OFF, ON, PRESS, RAMP.
- OFF/ON:
  - `rise` → PRESS, hold_cnt cleared, prior on/off remembered.
  - `fall` is ignored.
- PRESS:
  - hold_cnt increments every cycle.
  - `fall` while hold_cnt ≤ HOLD_CYC-1 is a short press: toggle `led_on`, go to ON or OFF accordingly.
  - hold_cnt == HOLD_CYC-1 with no `fall` → RAMP; `led_on` forced 1; step_cnt cleared.
  - `led_on` holds its prior value throughout PRESS.
- RAMP:
  - step_cnt counts 0..STEP_CYC-1 and wraps.
  - On each wrap, `level` moves ±1 per the direction.
  - Saturating: floor LVL_MIN=1, ceiling 2^DUTY_W-1. No wrap-around; at a limit `level` holds.
  - `fall` → ON and the direction toggles.
- `rise` is ignored in PRESS and RAMP.
- `rise` and `fall` in the same cycle are both ignored, in any state.
- PWM:
  - Free-running DUTY_W-bit counter, running from reset regardless of state.
  - `pwm_out` = registered (`led_on` && pwm_cnt < `level`).
  - Duty = level/2^DUTY_W; `level` max gives 255/256 high.
- `level` is retained through OFF. Turning back on restores the last brightness.

## Timing

- All outputs are registered. No combinational path from inputs to outputs.
- `rise` sampled at edge k:
  - state = PRESS from cycle k+1.
  - If no `fall` arrives, RAMP from cycle k+1+HOLD_CYC.
- Short press: `fall` sampled at edge n → `led_on` updated at n+1.
- `fall` arriving in the same cycle that hold_cnt reaches HOLD_CYC-1 counts as a short press; `fall` wins.
- Ramp: first `level` change STEP_CYC cycles after RAMP entry, then every STEP_CYC cycles.
- On RAMP exit, `level` is frozen at the `fall` edge. No step is taken on that edge.
- `pwm_out` lags a `level`/`led_on` change by 1 cycle at the next compare.
- `rst` mid-operation (any state) wins over all inputs. All outputs take their reset values one edge later.

## Structure

- Package `led_dim_pkg`:
  - state enum `dim_state_t` (OFF, ON, PRESS, RAMP).
  - direction enum (UP, DOWN).
  - constant LVL_MIN=1.
- Sub-module `pwm_gen` (params DUTY_W; ports clk, rst, en, duty, pwm): PWM counter plus compare register.
- `led_dim_ctrl` holds the FSM, hold/step counters, direction flag and `level` register.
- Counter widths are derived with $clog2 of HOLD_CYC and STEP_CYC.

## Test plan

All scenarios use DUTY_W=8, HOLD_CYC=20, STEP_CYC=4.

- Reset: `rst`=1 for 3 cycles → `led_on`=0, `pwm_out`=0, `level`=255. `rst` mid-RAMP → same values one edge later.
- Short press: `rise`, then `fall` 5 cycles later → `led_on`=1 next cycle, `pwm_out` high 255 of every 256 cycles. Repeat → `led_on`=0, `pwm_out` stays 0.
- Long press from ON: `fall` sampled 61 cycles after `rise` → `level`=245, state ON. Next long press ramps up, stops at 255 and holds (no wrap to 0).
- Floor saturation: hold down-ramp for 1200 cycles → `level` stops at 1, never 0. Long press from OFF → `led_on`=1 at cycle rise+21.
- Boundary:
  - `fall` at the cycle hold_cnt==19 → short-press toggle, `level` unchanged.
  - `rise`+`fall` in the same cycle → no state change.
  - `fall` in OFF → ignored.

Source files
------------

// File: rtl/led_dim_pkg.sv
// led_dim_pkg: shared state/direction types and brightness floor for the LED dimmer
package led_dim_pkg;
    typedef enum logic [1:0] {OFF, ON, PRESS, RAMP} dim_state_t;
    typedef enum logic {UP, DOWN} dir_t;
    localparam int LVL_MIN = 1;
endpackage

// File: rtl/led_dim_ctrl_pwm.sv
// pwm_gen: free-running counter with registered duty compare
module pwm_gen #(
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm
);
    logic [DUTY_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            pwm <= en && (cnt < duty);
        end
    end
endmodule

// File: rtl/led_dim_ctrl.sv
// led_dim_ctrl: single-button dimmer, short press toggles, long hold ramps brightness
module led_dim_ctrl
    import led_dim_pkg::*;
#(
    parameter int DUTY_W   = 8,
    parameter int HOLD_CYC = 25_000_000,
    parameter int STEP_CYC = 390_625
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rise,
    input  logic              fall,
    output logic [DUTY_W-1:0] level,
    output logic              led_on,
    output logic              pwm_out
);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [DUTY_W-1:0] LVL_MAX = '1;
    localparam logic [DUTY_W-1:0] LVL_FLOOR = DUTY_W'(LVL_MIN);
    dim_state_t        state, state_n;
    dir_t              dir, dir_n;
    logic [HW-1:0]     hold_cnt, hold_n;
    logic [SW-1:0]     step_cnt, step_n;
    logic              led_on_n;
    logic [DUTY_W-1:0] level_n;
    logic              rise_v, fall_v, hold_hit, step_hit, step_now;
    // Simultaneous rise and fall cancel each other out.
    assign rise_v   = rise & ~fall;
    assign fall_v   = fall & ~rise;
    assign hold_hit = hold_cnt == HW'(HOLD_CYC - 1);
    assign step_hit = step_cnt == SW'(STEP_CYC - 1);
    assign step_now = (state == RAMP) && step_hit && !fall_v;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            dir      <= DOWN;
            hold_cnt <= '0;
            step_cnt <= '0;
            led_on   <= 1'b0;
            level    <= LVL_MAX;
        end else begin
            state    <= state_n;
            dir      <= dir_n;
            hold_cnt <= hold_n;
            step_cnt <= step_n;
            led_on   <= led_on_n;
            level    <= level_n;
        end
    end
    always_comb begin
        state_n = state;
        unique case (state)
            OFF, ON: if (rise_v) state_n = PRESS;
            PRESS:   state_n = fall_v ? (led_on ? OFF : ON) : hold_hit ? RAMP : PRESS;
            RAMP:    if (fall_v) state_n = ON;
            default: state_n = OFF;
        endcase
    end
    // A release on the last hold cycle still counts as a short press.
    always_comb begin
        hold_n   = (state == PRESS && !hold_hit) ? hold_cnt + 1'b1 : '0;
        step_n   = (state == RAMP && !step_hit) ? step_cnt + 1'b1 : '0;
        led_on_n = (state != PRESS) ? led_on : fall_v ? !led_on : hold_hit ? 1'b1 : led_on;
        dir_n    = (state == RAMP && fall_v) ? ((dir == UP) ? DOWN : UP) : dir;
        level_n  = !step_now ? level :
                   (dir == UP) ? ((level == LVL_MAX) ? level : level + 1'b1) :
                   ((level <= LVL_FLOOR) ? level : level - 1'b1);
    end
    pwm_gen #(.DUTY_W(DUTY_W)) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .en   (led_on),
        .duty (level),
        .pwm  (pwm_out)
    );
endmodule

// File: tb/tb_led_dim_ctrl.sv
// tb_led_dim_ctrl: directed stimulus with a timestamp-based behavioural model checked every cycle
module tb_led_dim_ctrl;
    localparam int DUTY_W = 8;
    localparam int HOLD = 20;
    localparam int STEP = 4;
    localparam int PERIOD = 256;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rise = 1'b0;
    logic fall = 1'b0;
    logic [DUTY_W-1:0] level;
    logic led_on, pwm_out;
    int passed = 0;
    int total = 0;
    led_dim_ctrl #(.DUTY_W(DUTY_W), .HOLD_CYC(HOLD), .STEP_CYC(STEP)) dut (
        .clk     (clk),
        .rst     (rst),
        .rise    (rise),
        .fall    (fall),
        .level   (level),
        .led_on  (led_on),
        .pwm_out (pwm_out)
    );
    always #5 clk = ~clk;
    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask
    // Model: press/ramp timing derived from edge timestamps rather than counters.
    int cyc = 0, rst_cyc = 0, t0 = 0, tr = 0, m_level = 255;
    bit m_valid = 0, m_on = 0, m_up = 0, m_press = 0, m_ramp = 0, m_pwm = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_valid = 1; rst_cyc = cyc; m_on = 0; m_up = 0;
            m_press = 0; m_ramp = 0; m_level = 255; m_pwm = 0;
        end else begin
            bit ev_r, ev_f;
            ev_r = rise && !fall;
            ev_f = fall && !rise;
            m_pwm = m_on && (((cyc - rst_cyc - 1) % PERIOD) < m_level);
            if (m_press) begin
                if (ev_f) begin
                    m_on = !m_on;
                    m_press = 0;
                end else if (cyc - t0 == HOLD) begin
                    m_press = 0; m_ramp = 1; m_on = 1; tr = cyc;
                end
            end else if (m_ramp) begin
                if (ev_f) begin
                    m_ramp = 0;
                    m_up = !m_up;
                end else if ((cyc - tr) % STEP == 0) begin
                    m_level = m_up ? ((m_level < 255) ? m_level + 1 : 255)
                                   : ((m_level > 1) ? m_level - 1 : 1);
                end
            end else if (ev_r) begin
                m_press = 1;
                t0 = cyc;
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("level", int'(level), m_level);
            check("led_on", int'(led_on), int'(m_on));
            check("pwm_out", int'(pwm_out), int'(m_pwm));
        end
    end
    task automatic press(input int len);
        rise = 1'b1;
        @(negedge clk);
        rise = 1'b0;
        repeat (len - 1) @(negedge clk);
        fall = 1'b1;
        @(negedge clk);
        fall = 1'b0;
    endtask
    task automatic count_pwm(output int highs);
        highs = 0;
        @(negedge clk);
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            highs += int'(pwm_out);
        end
    endtask
    initial begin
        int highs;
        repeat (3) @(negedge clk);
        check("rst_level", int'(level), 255);
        check("rst_led_on", int'(led_on), 0);
        check("rst_pwm", int'(pwm_out), 0);
        rst = 1'b0;
        fall = 1'b1;
        @(negedge clk);
        fall = 1'b0;
        check("fall_in_off", int'(led_on), 0);
        rise = 1'b1;
        fall = 1'b1;
        @(negedge clk);
        rise = 1'b0;
        fall = 1'b0;
        repeat (HOLD + 5) @(negedge clk);
        check("rise_fall_same_led", int'(led_on), 0);
        check("rise_fall_same_level", int'(level), 255);
        press(5);
        check("short_on", int'(led_on), 1);
        count_pwm(highs);
        check("pwm_duty_255", highs, 255);
        press(5);
        check("short_off", int'(led_on), 0);
        count_pwm(highs);
        check("pwm_off", highs, 0);
        press(HOLD);
        check("boundary_short_led", int'(led_on), 1);
        check("boundary_short_level", int'(level), 255);
        press(61);
        check("ramp_down_245", int'(level), 245);
        check("model_245", m_level, 245);
        repeat (HOLD) @(negedge clk);
        check("held_in_on", int'(level), 245);
        press(200);
        check("ramp_up_ceiling", int'(level), 255);
        check("ramp_up_led", int'(led_on), 1);
        press(5);
        check("off_again", int'(led_on), 0);
        rise = 1'b1;
        @(negedge clk);
        rise = 1'b0;
        repeat (HOLD - 1) @(negedge clk);
        check("long_from_off_before", int'(led_on), 0);
        @(negedge clk);
        check("long_from_off_at_21", int'(led_on), 1);
        repeat (1200) @(negedge clk);
        fall = 1'b1;
        @(negedge clk);
        fall = 1'b0;
        check("floor_level", int'(level), 1);
        press(5);
        press(5);
        check("retained_through_off", int'(level), 1);
        check("retained_led", int'(led_on), 1);
        rise = 1'b1;
        @(negedge clk);
        rise = 1'b0;
        repeat (40) @(negedge clk);
        check("ramping_up_from_floor", int'(level > 1), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_ramp_rst_level", int'(level), 255);
        check("mid_ramp_rst_led", int'(led_on), 0);
        check("mid_ramp_rst_pwm", int'(pwm_out), 0);
        rst = 1'b0;
        press(5);
        check("after_rst_on", int'(led_on), 1);
        press(HOLD + 1 + STEP * 3);
        check("after_rst_dir_down", int'(level), 252);
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
